pipe_column_gen: RTL and testbench

//  Transmit side of the pipe-column interface consumed by the 16 per-row field modules.

---
 rtl/pipe_column_gen.sv | 149 ++++++++++++++
 tb/tb_pipe_column_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_column_gen.sv
// Pipe-column generator: produces scroll/gravity tick pulses and one 16-bit pipe
// column per scroll tick, alternating empty spacing runs with fixed-height-gap pipes.
module pipe_column_gen #(
  parameter int         MOVE_DIV     = 8,
  parameter int         GRAV_DIV     = 4,
  parameter int         PIPE_SPACING = 6,
  parameter int         PIPE_WIDTH   = 2,
  parameter int         GAP_HEIGHT   = 4,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        gameOver,
  output logic        movePipeOn,
  output logic        gravityOn,
  output logic        newPipeOn,
  output logic [15:0] newPipeCol,
  output logic [3:0]  gapBase,
  output logic [1:0]  state_dbg
);

  localparam int MW      = $clog2(MOVE_DIV);
  localparam int GW      = $clog2(GRAV_DIV);
  localparam int CMAX    = (PIPE_SPACING > PIPE_WIDTH) ? PIPE_SPACING : PIPE_WIDTH;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int GAP_MOD = 14 - GAP_HEIGHT + 1;

  localparam logic [7:0]    SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [GW-1:0] GRAV_LAST  = GW'(GRAV_DIV - 1);
  localparam logic [CW-1:0] SPACE_LAST = CW'(PIPE_SPACING - 1);
  localparam logic [CW-1:0] PIPE_LAST  = CW'(PIPE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPACE = 2'd1,
    PIPE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] move_cnt_q, move_cnt_d;
  logic [GW-1:0] grav_cnt_q, grav_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    gap_base_q, gap_base_d;
  logic          move_pulse_q, move_pulse_d;
  logic          grav_pulse_q, grav_pulse_d;
  logic          new_on_q, new_on_d;
  logic [15:0]   new_col_q, new_col_d;
  logic          move_tick, grav_tick;

  // 1 = pipe, 0 = open row inside the gap window starting at gb.
  function automatic logic [15:0] col_for(input logic [3:0] gb);
    logic [15:0] c;
    c = '1;
    for (int r = 0; r < 16; r++) begin
      if (r >= int'(gb) && r < int'(gb) + GAP_HEIGHT) c[r] = 1'b0;
    end
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    move_cnt_d   = move_cnt_q;
    grav_cnt_d   = grav_cnt_q;
    col_cnt_d    = col_cnt_q;
    gap_base_d   = gap_base_q;
    move_pulse_d = 1'b0;
    grav_pulse_d = 1'b0;
    new_on_d     = 1'b0;
    new_col_d    = '0;
    move_tick    = (move_cnt_q == MOVE_LAST);
    grav_tick    = (grav_cnt_q == GRAV_LAST);
    // LFSR free-runs whenever out of reset, regardless of game state.
    lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);

    if (!enable) begin
      state_d    = IDLE;
      move_cnt_d = '0;
      grav_cnt_d = '0;
      col_cnt_d  = '0;
    end else if (state_q == IDLE) begin
      move_cnt_d = '0;
      grav_cnt_d = '0;
      col_cnt_d  = '0;
      if (!gameOver) state_d = SPACE;
    end else if (!gameOver) begin
      move_cnt_d   = move_tick ? '0 : move_cnt_q + 1'b1;
      grav_cnt_d   = grav_tick ? '0 : grav_cnt_q + 1'b1;
      grav_pulse_d = grav_tick;
      if (move_tick) begin
        move_pulse_d = 1'b1;
        if (state_q == SPACE) begin
          if (col_cnt_q == SPACE_LAST) begin
            gap_base_d = 4'(1 + (int'(lfsr_q[3:0]) % GAP_MOD));
            state_d    = PIPE;
            col_cnt_d  = '0;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end else begin
          new_on_d  = 1'b1;
          new_col_d = col_for(gap_base_q);
          if (col_cnt_q == PIPE_LAST) begin
            state_d   = SPACE;
            col_cnt_d = '0;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      move_cnt_q   <= '0;
      grav_cnt_q   <= '0;
      col_cnt_q    <= '0;
      lfsr_q       <= SEED;
      gap_base_q   <= '0;
      move_pulse_q <= 1'b0;
      grav_pulse_q <= 1'b0;
      new_on_q     <= 1'b0;
      new_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      move_cnt_q   <= move_cnt_d;
      grav_cnt_q   <= grav_cnt_d;
      col_cnt_q    <= col_cnt_d;
      lfsr_q       <= lfsr_d;
      gap_base_q   <= gap_base_d;
      move_pulse_q <= move_pulse_d;
      grav_pulse_q <= grav_pulse_d;
      new_on_q     <= new_on_d;
      new_col_q    <= new_col_d;
    end
  end

  assign movePipeOn = move_pulse_q;
  assign gravityOn  = grav_pulse_q;
  assign newPipeOn  = new_on_q;
  assign newPipeCol = new_col_q;
  assign gapBase    = gap_base_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pipe_column_gen.sv
// Bench for pipe_column_gen: a tick-count reference model predicts every output
// each cycle; directed steps cover timing, freeze, random enable/freeze and async reset.
module tb_pipe_column_gen;

  localparam int MOVE_DIV = 8;
  localparam int GRAV_DIV = 4;
  localparam int SPACING  = 6;
  localparam int WIDTH    = 2;
  localparam int GAP_H    = 4;
  localparam int PERIOD   = SPACING + WIDTH;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        gameOver = 1'b0;
  logic        movePipeOn, gravityOn, newPipeOn;
  logic [15:0] newPipeCol;
  logic [3:0]  gapBase;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  pipe_column_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .gameOver(gameOver),
    .movePipeOn(movePipeOn), .gravityOn(gravityOn), .newPipeOn(newPipeOn),
    .newPipeCol(newPipeCol), .gapBase(gapBase), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // reference model: active edges since start (a) and scroll ticks since start (k)
  bit          running;
  int          a, k;
  logic [7:0]  lfsr_m;
  logic [3:0]  gap_m;
  logic        e_move, e_grav, e_new;
  logic [15:0] e_col;
  logic [15:0] exp_q[$];
  bit          seen_gap[16];

  function automatic logic [15:0] gap_column(input int g);
    logic [15:0] c;
    for (int r = 0; r < 16; r++) c[r] = (r >= g && r < g + GAP_H) ? 1'b0 : 1'b1;
    return c;
  endfunction

  task automatic model_reset();
    running = 0; a = 0; k = 0;
    lfsr_m = 8'hA5; gap_m = 4'd0;
    e_move = 0; e_grav = 0; e_new = 0; e_col = '0;
  endtask

  task automatic model_edge();
    logic [7:0] old;
    int pos;
    if (!reset) begin
      model_reset();
    end else begin
      old = lfsr_m;
      lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
      e_move = 0; e_grav = 0; e_new = 0; e_col = '0;
      if (!enable) begin
        running = 0; a = 0; k = 0;
      end else if (!running) begin
        if (!gameOver) begin running = 1; a = 0; k = 0; end
      end else if (!gameOver) begin
        a++;
        if (a % GRAV_DIV == 0) e_grav = 1;
        if (a % MOVE_DIV == 0) begin
          e_move = 1;
          k++;
          pos = (k - 1) % PERIOD;
          if (pos >= SPACING) begin
            e_new = 1;
            e_col = gap_column(int'(gap_m));
          end
          if (pos == SPACING - 1) gap_m = 4'(1 + (int'(old[3:0]) % (14 - GAP_H + 1)));
        end
      end
    end
    exp_q.push_back(e_col);
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] ec;
    ec = exp_q.pop_front();
    chk("movePipeOn", {15'd0, movePipeOn}, {15'd0, e_move});
    chk("gravityOn", {15'd0, gravityOn}, {15'd0, e_grav});
    chk("newPipeOn", {15'd0, newPipeOn}, {15'd0, e_new});
    chk("newPipeCol", newPipeCol, ec);
    chk("gapBase", {12'd0, gapBase}, {12'd0, gap_m});
  endtask

  // driver: inputs change on the falling edge, outputs checked 1ns after the rising edge
  task automatic step(input logic rst, input logic en, input logic go);
    @(negedge clk);
    reset = rst; enable = en; gameOver = go;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int first_move, first_grav, both, n, pulses, cols, distinct;
    bit found;
    model_reset();

    // reset held with clock running, then released with enable low
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("reset_state", {14'd0, state_dbg}, 16'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("idle_state", {14'd0, state_dbg}, 16'd0);

    // enabling edge is cycle 0; scroll at 8,16,..; gravity at 4,8,..
    step(1'b1, 1'b1, 1'b0);
    first_move = -1; first_grav = -1; both = 0;
    for (int i = 1; i <= 130; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (movePipeOn && first_move < 0) first_move = i;
      if (gravityOn && first_grav < 0) first_grav = i;
      if (movePipeOn && gravityOn) both++;
    end
    chk("first_move_cycle", 16'(first_move), 16'd8);
    chk("first_grav_cycle", 16'(first_grav), 16'd4);
    chk("coincident_ticks", 16'(both), 16'd16);

    // freeze for 20 cycles during the first column of a pipe
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (newPipeOn) found = 1;
    end
    chk("pipe_reached_before_freeze", {15'd0, found}, 16'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
    n = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
      if (newPipeOn) found = 1;
    end
    chk("second_col_after_release", 16'(n), 16'd8);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0);

    // random enable drops and freezes
    for (int i = 0; i < 1500; i++)
      step(1'b1, ($urandom_range(0, 199) != 0), ($urandom_range(0, 15) == 0));

    // long run: 64 pipes, structural checks on every pipe column
    step(1'b1, 1'b0, 1'b0);
    cols = 0;
    for (int i = 0; i < 9000 && cols < 2 * 64; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (newPipeOn) begin
        cols++;
        seen_gap[gapBase] = 1;
        chk("col_edge_rows", {14'd0, newPipeCol[15], newPipeCol[0]}, 16'd3);
        chk("gap_in_range", {15'd0, (gapBase >= 4'd1 && gapBase <= 4'd11)}, 16'd1);
      end
    end
    chk("pipe_cols_seen", 16'(cols), 16'd128);
    distinct = 0;
    for (int g = 0; g < 16; g++) if (seen_gap[g]) distinct++;
    chk("distinct_gaps_ge4", {15'd0, (distinct >= 4)}, 16'd1);

    // asynchronous reset in the middle of a pipe column
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (newPipeOn) found = 1;
    end
    chk("pipe_reached_before_reset", {15'd0, found}, 16'd1);
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("async_move", {15'd0, movePipeOn}, 16'd0);
    chk("async_new", {15'd0, newPipeOn}, 16'd0);
    chk("async_col", newPipeCol, 16'd0);
    chk("async_gap", {12'd0, gapBase}, 16'd0);
    chk("async_state", {14'd0, state_dbg}, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    pulses = 0; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (movePipeOn) pulses++;
      if (newPipeOn) found = 1;
    end
    chk("first_pipe_pulse_after_reset", 16'(pulses), 16'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
